// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the pipeline.
// Selects the register-file write data from the ALU, memory, link or immediate
// source. A load whose data has not arrived parks the stage in WAIT_MEM until
// mem_valid_i. The outputs rf_we_o, rf_waddr_o and rf_wdata_o are registered,
// and rf_wdata_o also serves as the forwarding source.
// Optional feature macro: WB_LOAD_EXT_EN. When it is defined, load data is
// lane-extracted and sign- or zero-extended. When it is undefined, mem_data_i
// passes through unmodified.
module wb_stage #(
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          valid_i,
   output logic                          ready_o,
   input  logic [AW-1:0]                 rd_i,
   input  logic                          reg_write_i,
   input  logic [1:0]                    wb_sel_i,
   input  logic [XLEN-1:0]               alu_data_i,
   input  logic [XLEN-1:0]               link_data_i,
   input  logic [XLEN-1:0]               imm_data_i,
   input  logic                          mem_valid_i,
   input  logic [XLEN-1:0]               mem_data_i,
   input  logic [1:0]                    mem_size_i,
   input  logic                          mem_unsigned_i,
   input  logic [$clog2(XLEN/8)-1:0]     addr_lo_i,
   output logic                          rf_we_o,
   output logic [AW-1:0]                 rf_waddr_o,
   output logic [XLEN-1:0]               rf_wdata_o,
   output logic                          busy_o
);

   localparam int OW = $clog2(XLEN/8);

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_MEM = 1'b1
   } state_t;

   state_t          state_reg;
   logic [AW-1:0]   hold_rd_reg;
   logic            hold_we_reg;
   logic [XLEN-1:0] ld_data;
   logic [XLEN-1:0] sel_data;

`ifdef WB_LOAD_EXT_EN
   logic [1:0]      hold_size_reg;
   logic            hold_uns_reg;
   logic [OW-1:0]   hold_lo_reg;
   logic [1:0]      ld_size;
   logic            ld_uns;
   logic [OW-1:0]   ld_lo;
   logic [OW-1:0]   ld_off;
   logic [XLEN-1:0] ld_shift;

   // Use the held load attributes while waiting, otherwise the live ones
   always_comb begin
      if (state_reg == WAIT_MEM) begin
         ld_size = hold_size_reg;
         ld_uns  = hold_uns_reg;
         ld_lo   = hold_lo_reg;
      end else begin
         ld_size = mem_size_i;
         ld_uns  = mem_unsigned_i;
         ld_lo   = addr_lo_i;
      end
   end

   // Align the byte offset to the access size, then shift the lane down to bit 0
   always_comb begin
      ld_off = ld_lo;
      case (ld_size)
         2'b00:   ld_off = ld_lo;
         2'b01:   ld_off = ld_lo & ~OW'(1);
         2'b10:   ld_off = ld_lo & ~OW'(3);
         default: ld_off = '0;
      endcase
      ld_shift = mem_data_i >> {ld_off, 3'b000};
   end

   // Sign- or zero-extend the extracted lane to XLEN
   always_comb begin
      ld_data = ld_shift;
      case (ld_size)
         2'b00: ld_data = ld_uns ? XLEN'(ld_shift[7:0])  : XLEN'($signed(ld_shift[7:0]));
         2'b01: ld_data = ld_uns ? XLEN'(ld_shift[15:0]) : XLEN'($signed(ld_shift[15:0]));
         2'b10: ld_data = ld_uns ? XLEN'(ld_shift[31:0]) : XLEN'($signed(ld_shift[31:0]));
         // A dword on a 32-bit datapath degenerates to a full-width word.
         default: ld_data = ld_shift;
      endcase
   end
`else
   logic unused_ld_attr;
   assign unused_ld_attr = ^{mem_size_i, mem_unsigned_i, addr_lo_i};
   assign ld_data = mem_data_i;
`endif

   // Select the writeback source for a bundle that completes in IDLE
   always_comb begin
      sel_data = alu_data_i;
      case (wb_sel_i)
         2'b00:   sel_data = alu_data_i;
         2'b01:   sel_data = ld_data;
         2'b10:   sel_data = link_data_i;
         default: sel_data = imm_data_i;
      endcase
   end

   assign ready_o = (state_reg == IDLE);
   assign busy_o  = (state_reg == WAIT_MEM);

   // Writeback FSM: a completing bundle writes on the next edge, and a load
   // without data is parked until mem_valid_i
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         rf_we_o       <= 1'b0;
         rf_waddr_o    <= '0;
         rf_wdata_o    <= '0;
         hold_rd_reg   <= '0;
         hold_we_reg   <= 1'b0;
`ifdef WB_LOAD_EXT_EN
         hold_size_reg <= '0;
         hold_uns_reg  <= 1'b0;
         hold_lo_reg   <= '0;
`endif
      end else begin
         rf_we_o <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (valid_i) begin
                  if ((wb_sel_i != 2'b01) || mem_valid_i) begin
                     rf_waddr_o <= rd_i;
                     rf_wdata_o <= sel_data;
                     rf_we_o    <= reg_write_i && (rd_i != '0);
                  end else begin
                     hold_rd_reg   <= rd_i;
                     hold_we_reg   <= reg_write_i;
`ifdef WB_LOAD_EXT_EN
                     hold_size_reg <= mem_size_i;
                     hold_uns_reg  <= mem_unsigned_i;
                     hold_lo_reg   <= addr_lo_i;
`endif
                     state_reg     <= WAIT_MEM;
                  end
               end
            end
            WAIT_MEM: begin
               if (mem_valid_i) begin
                  rf_waddr_o <= hold_rd_reg;
                  rf_wdata_o <= ld_data;
                  rf_we_o    <= hold_we_reg && (hold_rd_reg != '0);
                  state_reg  <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: self-checking bench for wb_stage (XLEN=32, AW=5).
// The bench pushes expected register-file writes to a scoreboard queue when it
// drives the stimulus. A negedge monitor pops and compares every rf_we_o pulse.
module tb_wb_stage;

   localparam int XLEN = 32;
   localparam int AW   = 5;
   localparam int OW   = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            valid_i = 1'b0;
   logic            ready_o;
   logic [AW-1:0]   rd_i = '0;
   logic            reg_write_i = 1'b0;
   logic [1:0]      wb_sel_i = 2'b00;
   logic [XLEN-1:0] alu_data_i = '0;
   logic [XLEN-1:0] link_data_i = '0;
   logic [XLEN-1:0] imm_data_i = '0;
   logic            mem_valid_i = 1'b0;
   logic [XLEN-1:0] mem_data_i = '0;
   logic [1:0]      mem_size_i = 2'b00;
   logic            mem_unsigned_i = 1'b0;
   logic [OW-1:0]   addr_lo_i = '0;
   logic            rf_we_o;
   logic [AW-1:0]   rf_waddr_o;
   logic [XLEN-1:0] rf_wdata_o;
   logic            busy_o;

   wb_stage #(.XLEN(XLEN), .AW(AW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .valid_i        (valid_i),
      .ready_o        (ready_o),
      .rd_i           (rd_i),
      .reg_write_i    (reg_write_i),
      .wb_sel_i       (wb_sel_i),
      .alu_data_i     (alu_data_i),
      .link_data_i    (link_data_i),
      .imm_data_i     (imm_data_i),
      .mem_valid_i    (mem_valid_i),
      .mem_data_i     (mem_data_i),
      .mem_size_i     (mem_size_i),
      .mem_unsigned_i (mem_unsigned_i),
      .addr_lo_i      (addr_lo_i),
      .rf_we_o        (rf_we_o),
      .rf_waddr_o     (rf_waddr_o),
      .rf_wdata_o     (rf_wdata_o),
      .busy_o         (busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
      int              cyc;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // The write is expected on the edge that ends the current cycle.
   task automatic push(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      exp_t e;
      e.addr = a;
      e.data = d;
      e.cyc  = cyc + 1;
      sb_q.push_back(e);
   endtask

   // Monitor: every write pulse must match the head of the scoreboard
   always @(negedge clk) begin
      if (rf_we_o === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_write", {59'd0, rf_waddr_o}, 64'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("wr_addr", {59'd0, rf_waddr_o}, {59'd0, e.addr});
            chk("wr_data", {32'd0, rf_wdata_o}, {32'd0, e.data});
            chk("wr_cycle", 64'(cyc), 64'(e.cyc));
            $display("write rd=%0d data=%08h cyc=%0d", rf_waddr_o, rf_wdata_o, cyc);
         end
      end
   end

   // Load vectors: size, unsigned, offset and the expected extended result
   logic [1:0]      lv_size [7];
   logic            lv_uns  [7];
   logic [OW-1:0]   lv_lo   [7];
   logic [XLEN-1:0] lv_ext  [7];

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      lv_size[0] = 2'b00; lv_uns[0] = 1'b0; lv_lo[0] = 2'd2; lv_ext[0] = 32'hFFFF_FFFF;
      lv_size[1] = 2'b00; lv_uns[1] = 1'b1; lv_lo[1] = 2'd2; lv_ext[1] = 32'h0000_00FF;
      lv_size[2] = 2'b01; lv_uns[2] = 1'b0; lv_lo[2] = 2'd2; lv_ext[2] = 32'hFFFF_80FF;
      lv_size[3] = 2'b00; lv_uns[3] = 1'b0; lv_lo[3] = 2'd0; lv_ext[3] = 32'h0000_0001;
      lv_size[4] = 2'b00; lv_uns[4] = 1'b0; lv_lo[4] = 2'd3; lv_ext[4] = 32'hFFFF_FF80;
      lv_size[5] = 2'b01; lv_uns[5] = 1'b1; lv_lo[5] = 2'd1; lv_ext[5] = 32'h0000_7F01;
      lv_size[6] = 2'b11; lv_uns[6] = 1'b0; lv_lo[6] = 2'd3; lv_ext[6] = 32'h80FF_7F01;

      // Reset state
      #12;
      chk("rst_we",    {63'd0, rf_we_o}, 64'd0);
      chk("rst_waddr", {59'd0, rf_waddr_o}, 64'd0);
      chk("rst_wdata", {32'd0, rf_wdata_o}, 64'd0);
      chk("rst_ready", {63'd0, ready_o}, 64'd1);
      chk("rst_busy",  {63'd0, busy_o}, 64'd0);
      step();
      rst_n = 1'b1;

      // ALU back-to-back
      for (int i = 1; i <= 3; i++) begin
         valid_i = 1'b1; wb_sel_i = 2'b00; reg_write_i = 1'b1;
         rd_i = AW'(i); alu_data_i = 32'h11 * i;
         push(AW'(i), 32'h11 * i);
         chk("alu_ready", {63'd0, ready_o}, 64'd1);
         step();
      end
      valid_i = 1'b0;
      chk("alu_ready_after", {63'd0, ready_o}, 64'd1);

      // Load wait: the attributes are captured at accept and then scrambled
      valid_i = 1'b1; wb_sel_i = 2'b01; rd_i = 5'd5; reg_write_i = 1'b1;
      mem_valid_i = 1'b0; mem_size_i = 2'b10; mem_unsigned_i = 1'b0; addr_lo_i = 2'd0;
      step();
      valid_i = 1'b1; wb_sel_i = 2'b00; rd_i = 5'd9; alu_data_i = 32'hDEAD;
      mem_size_i = 2'b00; addr_lo_i = 2'd1; mem_unsigned_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("wait_busy",  {63'd0, busy_o}, 64'd1);
         chk("wait_ready", {63'd0, ready_o}, 64'd0);
         if (i < 2) step();
      end
      step();
      valid_i = 1'b0;
      mem_valid_i = 1'b1; mem_data_i = 32'h0000_00F0;
      push(5'd5, 32'h0000_00F0);
      step();
      mem_valid_i = 1'b0;
      chk("load_ready_back", {63'd0, ready_o}, 64'd1);
      chk("load_busy_clear", {63'd0, busy_o}, 64'd0);

      // Writes to x0 and no-write bundles are suppressed but still accepted
      valid_i = 1'b1; wb_sel_i = 2'b10; rd_i = 5'd0; link_data_i = 32'h100; reg_write_i = 1'b1;
      chk("x0_ready", {63'd0, ready_o}, 64'd1);
      step();
      wb_sel_i = 2'b11; rd_i = 5'd4; imm_data_i = 32'h4444; reg_write_i = 1'b0;
      chk("nowr_ready", {63'd0, ready_o}, 64'd1);
      step();
      wb_sel_i = 2'b11; rd_i = 5'd8; imm_data_i = 32'h8888; reg_write_i = 1'b1;
      push(5'd8, 32'h8888);
      step();
      valid_i = 1'b0;
      chk("x0_ready_after", {63'd0, ready_o}, 64'd1);

      // Loads completing in IDLE, back to back
      mem_data_i = 32'h80FF_7F01;
      for (int i = 0; i < 7; i++) begin
         valid_i = 1'b1; wb_sel_i = 2'b01; mem_valid_i = 1'b1; reg_write_i = 1'b1;
         rd_i = AW'(10 + i);
         mem_size_i = lv_size[i]; mem_unsigned_i = lv_uns[i]; addr_lo_i = lv_lo[i];
`ifdef WB_LOAD_EXT_EN
         push(AW'(10 + i), lv_ext[i]);
`else
         push(AW'(10 + i), 32'h80FF_7F01);
`endif
         step();
         chk("ld_ready", {63'd0, ready_o}, 64'd1);
      end
      valid_i = 1'b0; mem_valid_i = 1'b0;

      // Stray memory data in IDLE
      mem_valid_i = 1'b1; mem_data_i = 32'h5555_AAAA;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("stray_ready", {63'd0, ready_o}, 64'd1);
         chk("stray_busy",  {63'd0, busy_o}, 64'd0);
      end
      mem_valid_i = 1'b0;

      // Reset while waiting for a load to rd=7
      valid_i = 1'b1; wb_sel_i = 2'b01; rd_i = 5'd7; reg_write_i = 1'b1;
      mem_size_i = 2'b10; mem_unsigned_i = 1'b0; addr_lo_i = 2'd0;
      step();
      valid_i = 1'b0;
      chk("pre_rst_busy", {63'd0, busy_o}, 64'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_we",    {63'd0, rf_we_o}, 64'd0);
      chk("arst_waddr", {59'd0, rf_waddr_o}, 64'd0);
      chk("arst_wdata", {32'd0, rf_wdata_o}, 64'd0);
      chk("arst_busy",  {63'd0, busy_o}, 64'd0);
      chk("arst_ready", {63'd0, ready_o}, 64'd1);
      step();
      rst_n = 1'b1;
      mem_valid_i = 1'b1; mem_data_i = 32'h7777_7777;
      step();
      step();
      mem_valid_i = 1'b0;
      chk("post_rst_ready", {63'd0, ready_o}, 64'd1);
      chk("post_rst_busy",  {63'd0, busy_o}, 64'd0);

      // Normal operation after reset
      valid_i = 1'b1; wb_sel_i = 2'b00; rd_i = 5'd6; alu_data_i = 32'h66; reg_write_i = 1'b1;
      push(5'd6, 32'h66);
      step();
      valid_i = 1'b0;

      step();
      step();
      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter XLEN, default 32, data width; legal values 32 and 64.
REQ-002 Parameter AW, default 5, register-file address width.
REQ-003 Local OW = $clog2(XLEN/8), the byte-offset width.
REQ-004 The block SHALL run on one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 valid_i  in  1  writeback bundle present.
REQ-008 ready_o  out  1  bundle accepted this cycle when valid_i&ready_o.
REQ-009 rd_i  in  AW  destination register.
REQ-010 reg_write_i  in  1  instruction writes rd.
REQ-011 wb_sel_i  in  2  source select: 00 ALU, 01 MEM, 10 LINK, 11 IMM.
REQ-012 alu_data_i / link_data_i / imm_data_i  in  XLEN each  candidate write data.
REQ-013 mem_valid_i  in  1  load data valid this cycle.
REQ-014 mem_data_i  in  XLEN  raw load word.
REQ-015 mem_size_i  in  2  00 byte, 01 half, 10 word, 11 dword.
REQ-016 mem_unsigned_i  in  1  zero-extend when 1, sign-extend when 0.
REQ-017 addr_lo_i  in  OW  byte offset of the load.
REQ-018 rf_we_o  out  1  register-file write strobe, registered.
REQ-019 rf_waddr_o  out  AW  write address, registered.
REQ-020 rf_wdata_o  out  XLEN  write data, registered; also the forwarding source.
REQ-021 busy_o  out  1  high while in WAIT_MEM.

Function
REQ-022 FSM has states IDLE and WAIT_MEM; ready_o = (state==IDLE) and busy_o = (state==WAIT_MEM), both Moore outputs.
REQ-023 In IDLE, an accepted bundle with wb_sel_i!=01, or with wb_sel_i==01 and mem_valid_i=1, SHALL complete: next edge loads rf_waddr_o=rd_i, rf_wdata_o=selected data, rf_we_o=reg_write_i&&(rd_i!=0).
REQ-024 In IDLE, an accepted bundle with wb_sel_i==01 and mem_valid_i=0 SHALL latch rd, reg_write, size, unsigned and addr_lo into holding registers and move to WAIT_MEM; rf_we_o=0 next cycle.
REQ-025 In WAIT_MEM, valid_i SHALL be ignored; on mem_valid_i=1 the next edge writes the held rd with the processed mem_data_i and returns to IDLE.
REQ-026 mem_valid_i in IDLE without a MEM-selected accepted bundle SHALL be ignored.
REQ-027 Latency: exactly one cycle from completion condition to rf_we_o; throughput is one bundle per cycle with no memory wait.
REQ-028 rf_we_o SHALL be a single-cycle pulse per completed instruction; rf_waddr_o/rf_wdata_o hold their last value while rf_we_o=0.
REQ-029 Writes to rd=0 SHALL be suppressed (rf_we_o=0) while the handshake and FSM still advance normally.

Reset
REQ-030 Assertion of rst_n=0 SHALL immediately force state=IDLE, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0 and all holding registers to 0.
REQ-031 Reset during WAIT_MEM SHALL abandon the pending load; no write occurs after deassertion, even if mem_valid_i=1.
REQ-032 The first rising edge after deassertion SHALL behave as normal IDLE operation.

Configuration
REQ-033 With WB_LOAD_EXT_EN defined: memory data is extracted at byte lane addr_lo_i (half: offset bit0 forced 0; word: offset bit1 forced 0 when XLEN=64) and sign- or zero-extended to XLEN per mem_unsigned_i; size 11 with XLEN=32 is treated as word.
REQ-034 With WB_LOAD_EXT_EN undefined: mem_data_i passes to rf_wdata_o unmodified; mem_size_i, mem_unsigned_i and addr_lo_i are ignored and not held.

Verification
REQ-035 ALU back-to-back: cycles 1-3 valid_i=1, sel=00, rd=1,2,3, alu=0x11,0x22,0x33 -> rf_we_o pulses on cycles 2-4 with matching addr/data; ready_o stays 1.
REQ-036 Load wait: sel=01, rd=5, mem_valid_i=0 for 3 cycles, then mem_data_i=0x000000F0 -> busy_o=1 and ready_o=0 for 3 cycles; one write rd=5, data 0xF0 one cycle after mem_valid_i.
REQ-037 x0: sel=10, rd=0, link=0x100, reg_write=1 -> rf_we_o stays 0, ready_o stays 1.
REQ-038 WB_LOAD_EXT_EN, XLEN=32: mem_data=0x80FF7F01, addr_lo=2, size=00, unsigned=0 -> 0xFFFFFFFF; unsigned=1 -> 0x000000FF; size=01, addr_lo=2, unsigned=0 -> 0xFFFF80FF.
REQ-039 Reset in WAIT_MEM: enter WAIT_MEM with rd=7, pulse rst_n low mid-cycle, then mem_valid_i=1 -> outputs 0 immediately, no write to rd=7, ready_o=1.
REQ-040 Stray memory data: IDLE, valid_i=0, mem_valid_i=1 -> no rf_we_o pulse, state remains IDLE.
